load_store_sequencer: RTL and testbench

LOAD_STORE_SEQUENCER -- requirements
Module: load_store_sequencer

---
 rtl/load_store_sequencer_pkg.sv | 23 ++
 rtl/lds_lane_align.sv | 34 +++
 rtl/load_store_sequencer.sv | 163 ++++++++++++++++
 tb/tb_load_store_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_sequencer_pkg.sv
// Shared encodings for the load/store sequencer: FSM states, opcode and
// pointer-update modes.
package load_store_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_WRBACK = 2'd3
  } state_t;

  localparam logic OP_LD = 1'b0;
  localparam logic OP_ST = 1'b1;

  // INCF 00 and 11 both mean "no pointer update"
  localparam logic [1:0] INCF_POSTINC = 2'b01;
  localparam logic [1:0] INCF_PREDEC  = 2'b10;

  function automatic logic incf_updates_ptr(input logic [1:0] incf);
    return (incf == INCF_POSTINC) || (incf == INCF_PREDEC);
  endfunction

endpackage

// File: rtl/lds_lane_align.sv
// Byte-lane steering between the core and a DATA_WIDTH-wide memory port:
// byte enables, store-byte replication and load-byte zero extension.
module lds_lane_align #(
  parameter int DATA_WIDTH = 16,
  parameter int LANE_BITS  = $clog2(DATA_WIDTH / 8)
) (
  input  logic                      i_byte,
  input  logic [LANE_BITS-1:0]      i_lane,
  input  logic [DATA_WIDTH-1:0]     i_store_data,
  input  logic [DATA_WIDTH-1:0]     i_mem_din,
  output logic [DATA_WIDTH/8-1:0]   o_be,
  output logic [DATA_WIDTH-1:0]     o_mem_dout,
  output logic [DATA_WIDTH-1:0]     o_load_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [7:0] w_lane_byte;

  assign w_lane_byte = i_mem_din[{i_lane, 3'b000} +: 8];

  always_comb begin
    o_be = '1;
    if (i_byte) begin
      o_be         = '0;
      o_be[i_lane] = 1'b1;
    end
  end

  // A byte store puts the byte on every lane; the enables pick the real one
  assign o_mem_dout  = i_byte ? {NB{i_store_data[7:0]}} : i_store_data;
  assign o_load_data = i_byte ? {{(DATA_WIDTH-8){1'b0}}, w_lane_byte} : i_mem_din;

endmodule

// File: rtl/load_store_sequencer.sv
// Single-outstanding load/store sequencer: computes the effective address,
// runs one memory access with timeout, then writes back data and pointer.
module load_store_sequencer
  import load_store_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 7
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_op,
  input  logic [1:0]              i_incf,
  input  logic                    i_byte,
  input  logic [ADDR_WIDTH-1:0]   i_base,
  input  logic [5:0]              i_offset,
  input  logic                    i_off_sub,
  input  logic [DATA_WIDTH-1:0]   i_store_data,
  input  logic                    i_mem_rdy,
  input  logic [DATA_WIDTH-1:0]   i_mem_din,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_dout,
  output logic                    o_mem_rd,
  output logic                    o_mem_wr,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [DATA_WIDTH-1:0]   o_load_data,
  output logic                    o_load_wen,
  output logic [ADDR_WIDTH-1:0]   o_ptr_data,
  output logic                    o_ptr_wen,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(NB - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t r_state, w_next;
  logic [7:0] r_wait;
  logic       r_timeout;
  logic       w_abort;

  logic                  r_op, r_byte, r_sub;
  logic [1:0]            r_incf;
  logic [ADDR_WIDTH-1:0] r_base, r_ea, r_ptr;
  logic [5:0]            r_offset;
  logic [DATA_WIDTH-1:0] r_store, r_load;

  logic [ADDR_WIDTH-1:0]   w_step, w_off, w_ea, w_mem_addr;
  logic [NB-1:0]           w_be;
  logic [DATA_WIDTH-1:0]   w_dout, w_lane_load;

  assign w_step = r_byte ? ADDR_WIDTH'(1) : ADDR_WIDTH'(NB);
  assign w_off  = ADDR_WIDTH'(r_offset);

  always_comb begin
    case (r_incf)
      INCF_POSTINC: w_ea = r_base;
      INCF_PREDEC:  w_ea = r_base - w_step;
      default:      w_ea = r_sub ? (r_base - w_off) : (r_base + w_off);
    endcase
  end

  assign w_mem_addr = r_byte ? r_ea : (r_ea & WORD_MASK);

  lds_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANE_BITS  (LANE_BITS)
  ) u_lane (
    .i_byte       (r_byte),
    .i_lane       (r_ea[LANE_BITS-1:0]),
    .i_store_data (r_store),
    .i_mem_din    (i_mem_din),
    .o_be         (w_be),
    .o_mem_dout   (w_dout),
    .o_load_data  (w_lane_load)
  );

  always_comb begin
    w_next     = r_state;
    w_abort    = 1'b0;
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_busy     = (r_state != ST_IDLE);
    o_done     = 1'b0;
    o_timeout  = 1'b0;
    o_load_wen = 1'b0;
    o_ptr_wen  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        o_mem_rd = (r_op == OP_LD);
        o_mem_wr = (r_op == OP_ST);
        if (i_mem_rdy) begin
          w_next = ST_WRBACK;
        end else if (r_wait == WAIT_LAST) begin
          w_next  = ST_WRBACK;
          w_abort = 1'b1;
        end
      end
      ST_WRBACK: begin
        o_done     = 1'b1;
        o_timeout  = r_timeout;
        o_load_wen = !r_timeout && (r_op == OP_LD);
        o_ptr_wen  = !r_timeout && incf_updates_ptr(r_incf);
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Data outputs are gated by state so reset clears them without resetting data regs
  assign o_mem_addr  = (r_state == ST_ACCESS) ? w_mem_addr : '0;
  assign o_mem_be    = (r_state == ST_ACCESS) ? w_be       : '0;
  assign o_mem_dout  = (r_state == ST_ACCESS) ? w_dout     : '0;
  assign o_load_data = o_load_wen ? r_load : '0;
  assign o_ptr_data  = o_ptr_wen  ? r_ptr  : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_ADDR) begin
        r_wait    <= '0;
        r_timeout <= 1'b0;
      end else if (r_state == ST_ACCESS && !i_mem_rdy) begin
        r_wait <= r_wait + 8'd1;
        if (w_abort) r_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_state == ST_IDLE && i_start) begin
      r_op     <= i_op;
      r_incf   <= i_incf;
      r_byte   <= i_byte;
      r_base   <= i_base;
      r_offset <= i_offset;
      r_sub    <= i_off_sub;
      r_store  <= i_store_data;
    end
    if (r_state == ST_ADDR) begin
      r_ea  <= w_ea;
      r_ptr <= (r_incf == INCF_POSTINC) ? (r_base + w_step) : w_ea;
    end
    if (r_state == ST_ACCESS && i_mem_rdy) begin
      r_load <= w_lane_load;
    end
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Scoreboard bench for load_store_sequencer (16-bit data/address, MAX_WAIT=4).
module tb_load_store_sequencer;
  import load_store_sequencer_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [1:0]    incf = 2'b00;
  logic          byt = 1'b0;
  logic [AW-1:0] base = '0;
  logic [5:0]    offset = '0;
  logic          off_sub = 1'b0;
  logic [DW-1:0] store_data = '0;
  logic          mem_rdy = 1'b0;
  logic [DW-1:0] mem_din = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          mem_rd, mem_wr;
  logic [1:0]    mem_be;
  logic [DW-1:0] load_data;
  logic          load_wen;
  logic [AW-1:0] ptr_data;
  logic          ptr_wen, busy, done, timeout;

  load_store_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_op(op), .i_incf(incf),
    .i_byte(byt), .i_base(base), .i_offset(offset), .i_off_sub(off_sub),
    .i_store_data(store_data), .i_mem_rdy(mem_rdy), .i_mem_din(mem_din),
    .o_mem_addr(mem_addr), .o_mem_dout(mem_dout), .o_mem_rd(mem_rd),
    .o_mem_wr(mem_wr), .o_mem_be(mem_be), .o_load_data(load_data),
    .o_load_wen(load_wen), .o_ptr_data(ptr_data), .o_ptr_wen(ptr_wen),
    .o_busy(busy), .o_done(done), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic rd; logic wr; logic [15:0] addr; logic [1:0] be;
    logic chk_dout; logic [15:0] dout; int cycles;
  } acc_t;
  typedef struct {
    int start; int lat; logic to; logic lwen; logic [15:0] ldata;
    logic pwen; logic [15:0] pdata;
  } cmp_t;

  acc_t acc_q[$];
  cmp_t cmp_q[$];
  int errs = 0;
  int checks = 0;
  int waits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic acc_t mk_acc(input logic rd, input logic wr, input logic [15:0] addr,
                                  input logic [1:0] be, input logic cd, input logic [15:0] dout,
                                  input int cycles);
    acc_t a;
    a.rd = rd; a.wr = wr; a.addr = addr; a.be = be;
    a.chk_dout = cd; a.dout = dout; a.cycles = cycles;
    return a;
  endfunction

  function automatic cmp_t mk_cmp(input int lat, input logic to, input logic lwen,
                                  input logic [15:0] ldata, input logic pwen,
                                  input logic [15:0] pdata);
    cmp_t c;
    c.start = 0; c.lat = lat; c.to = to; c.lwen = lwen; c.ldata = ldata;
    c.pwen = pwen; c.pdata = pdata;
    return c;
  endfunction

  // Memory responder and access monitor
  int   acnt = 0;
  acc_t cur;
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      if (acnt == 0) begin
        cur = mk_acc(mem_rd, mem_wr, mem_addr, mem_be, 1'b0, mem_dout, 0);
      end else begin
        chk("addr_stable", {16'h0, mem_addr}, {16'h0, cur.addr});
        chk("dout_stable", {16'h0, mem_dout}, {16'h0, cur.dout});
      end
      acnt++;
      mem_rdy = (acnt > waits);
    end else begin
      mem_rdy = 1'b0;
      if (acnt > 0) begin
        if (acc_q.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_access: addr 0x%0h, none required", cur.addr);
        end else begin
          acc_t e;
          e = acc_q.pop_front();
          chk("mem_rd", {31'h0, cur.rd}, {31'h0, e.rd});
          chk("mem_wr", {31'h0, cur.wr}, {31'h0, e.wr});
          chk("mem_addr", {16'h0, cur.addr}, {16'h0, e.addr});
          chk("mem_be", {30'h0, cur.be}, {30'h0, e.be});
          if (e.chk_dout) chk("mem_dout", {16'h0, cur.dout}, {16'h0, e.dout});
          chk("strobe_cycles", 32'(acnt), 32'(e.cycles));
        end
        acnt = 0;
      end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (done) begin
      if (cmp_q.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_done: got done=1 required none");
      end else begin
        cmp_t e;
        e = cmp_q.pop_front();
        chk("latency", 32'(cyc - e.start), 32'(e.lat));
        chk("busy_at_done", {31'h0, busy}, 32'h1);
        chk("timeout", {31'h0, timeout}, {31'h0, e.to});
        chk("load_wen", {31'h0, load_wen}, {31'h0, e.lwen});
        chk("ptr_wen", {31'h0, ptr_wen}, {31'h0, e.pwen});
        if (e.lwen) chk("load_data", {16'h0, load_data}, {16'h0, e.ldata});
        if (e.pwen) chk("ptr_data", {16'h0, ptr_data}, {16'h0, e.pdata});
      end
    end else if (load_wen || ptr_wen) begin
      checks++; errs++;
      $display("FAIL stray_wen: got load_wen=%0b ptr_wen=%0b without done", load_wen, ptr_wen);
    end
  end

  task automatic issue(input logic o, input logic [1:0] inc, input logic b,
                       input logic [15:0] bs, input logic [5:0] off, input logic sub,
                       input logic [15:0] sd, input logic [15:0] din, input int w,
                       input int hold, input acc_t a, input cmp_t c);
    @(posedge clk); #1;
    chk("idle_before_start", {31'h0, busy}, 32'h0);
    op = o; incf = inc; byt = b; base = bs; offset = off; off_sub = sub;
    store_data = sd; mem_din = din; waits = w;
    c.start = cyc;
    acc_q.push_back(a);
    cmp_q.push_back(c);
    start = 1'b1;
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 40 && cmp_q.size() != 0; i++) @(posedge clk);
    if (cmp_q.size() != 0) begin
      checks++; errs++;
      $display("FAIL done_wait: got no done within 40 cycles, required one");
      cmp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_timeout", {31'h0, timeout}, 32'h0);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_be", {30'h0, mem_be}, 32'h0);
    rst = 1'b0;

    // word LD, base-offset subtract, START held through busy
    issue(OP_LD, 2'b00, 1'b0, 16'h1000, 6'd5, 1'b1, 16'h0000, 16'hBEEF, 0, 3,
          mk_acc(1, 0, 16'h0FFA, 2'b11, 0, 16'h0, 1),
          mk_cmp(3, 0, 1, 16'hBEEF, 0, 16'h0));
    // word LD, pre-decrement wrapping below zero
    issue(OP_LD, 2'b10, 1'b0, 16'h0000, 6'd9, 1'b0, 16'h0000, 16'h5A5A, 0, 1,
          mk_acc(1, 0, 16'hFFFE, 2'b11, 0, 16'h0, 1),
          mk_cmp(3, 0, 1, 16'h5A5A, 1, 16'hFFFE));
    // byte ST, post-increment, odd lane
    issue(OP_ST, 2'b01, 1'b1, 16'h2001, 6'd7, 1'b0, 16'h1234, 16'h0000, 0, 1,
          mk_acc(0, 1, 16'h2001, 2'b10, 1, 16'h3434, 1),
          mk_cmp(3, 0, 0, 16'h0, 1, 16'h2002));
    // word LD with two wait cycles
    issue(OP_LD, 2'b00, 1'b0, 16'h3000, 6'h10, 1'b0, 16'h0000, 16'hCAFE, 2, 1,
          mk_acc(1, 0, 16'h3010, 2'b11, 0, 16'h0, 3),
          mk_cmp(5, 0, 1, 16'hCAFE, 0, 16'h0));
    // never ready: timeout suppresses both write-backs
    issue(OP_LD, 2'b01, 1'b0, 16'h4000, 6'd0, 1'b0, 16'h0000, 16'h1111, 255, 1,
          mk_acc(1, 0, 16'h4000, 2'b11, 0, 16'h0, 4),
          mk_cmp(6, 1, 0, 16'h0, 0, 16'h0));
    // byte LD after timeout, INCF=11 as plain offset, high lane
    issue(OP_LD, 2'b11, 1'b1, 16'h0010, 6'h3F, 1'b0, 16'h0000, 16'hAB12, 0, 1,
          mk_acc(1, 0, 16'h004F, 2'b10, 0, 16'h0, 1),
          mk_cmp(3, 0, 1, 16'h00AB, 0, 16'h0));
    // byte LD pre-decrement, low lane, offset ignored
    issue(OP_LD, 2'b10, 1'b1, 16'h0101, 6'h3F, 1'b1, 16'h0000, 16'hAB12, 0, 1,
          mk_acc(1, 0, 16'h0100, 2'b01, 0, 16'h0, 1),
          mk_cmp(3, 0, 1, 16'h0012, 1, 16'h0100));
    // word ST post-increment from unaligned top address
    issue(OP_ST, 2'b01, 1'b0, 16'hFFFF, 6'h3F, 1'b1, 16'h1234, 16'h0000, 0, 1,
          mk_acc(0, 1, 16'hFFFE, 2'b11, 1, 16'h1234, 1),
          mk_cmp(3, 0, 0, 16'h0, 1, 16'h0001));
    // word ST with one wait cycle
    issue(OP_ST, 2'b00, 1'b0, 16'h0FFF, 6'd1, 1'b0, 16'hA5C3, 16'h0000, 1, 1,
          mk_acc(0, 1, 16'h1000, 2'b11, 1, 16'hA5C3, 2),
          mk_cmp(4, 0, 0, 16'h0, 0, 16'h0));

    // reset during ACCESS: strobe drops without a clock edge, no completion
    @(posedge clk); #1;
    op = OP_LD; incf = 2'b01; byt = 1'b0; base = 16'h5000; offset = '0;
    off_sub = 1'b0; waits = 255; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    chk("rd_before_reset", {31'h0, mem_rd}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rd", {31'h0, mem_rd}, 32'h0);
    chk("async_rst_wr", {31'h0, mem_wr}, 32'h0);
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    chk("async_rst_addr", {16'h0, mem_addr}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_after_reset", {31'h0, busy}, 32'h0);
    chk("acc_q_drained", 32'(acc_q.size()), 32'h0);
    chk("cmp_q_drained", 32'(cmp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
